// File: rtl/pitch_estimator.sv
// pitch_estimator: inertial front end for the balance PID.
// Calibrates the gyro zero-rate offset from the first 2^CAL_LOG2 samples after
// reset, then presents an offset-compensated pitch rate and an integrated pitch
// angle, qualified by a one-cycle ptch_vld strobe.
// Build option: define PTCH_FUSION_EN to pull the integrator toward the
// accelerometer-derived angle by +/-1024 per sample. Without it, AZ is ignored
// and the angle is pure gyro integration.
//
// Handshake: vld is a one-cycle strobe with no back-pressure; every cycle with
// vld=1 is consumed on that rising edge, and ptch_vld pulses for one cycle on
// the same edge when a RUN sample updates ptch/ptch_rt. clr has priority over
// vld in RUN (the sample is dropped and no strobe is produced).
module pitch_estimator #(
  parameter int          CAL_LOG2  = 4,
  parameter logic [15:0] AZ_OFFSET = 16'hFE80
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vld,
  input  logic signed [15:0] ptch_rt_raw,
  input  logic signed [15:0] AZ,
  input  logic               clr,
  output logic signed [15:0] ptch,
  output logic signed [15:0] ptch_rt,
  output logic               ptch_vld,
  output logic               cal_done
);

  typedef enum logic {CAL = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CAL_LOG2:0] CAL_LAST = (CAL_LOG2 + 1)'((1 << CAL_LOG2) - 1);
  localparam logic [26:0]       INT_MAX  = 27'h3FF_FFFF;
  localparam logic [26:0]       INT_MIN  = 27'h400_0000;

  state_t state, state_nxt;

  logic signed [21:0] cal_acc;
  logic [CAL_LOG2:0]  cal_cnt;
  logic signed [15:0] offset;
  logic signed [26:0] int_q;

  logic               cal_last;
  logic signed [21:0] cal_sum;
  logic [16:0]        comp_wide;
  logic signed [15:0] comp;
  logic [27:0]        fuse;
  logic [27:0]        int_sum;
  logic signed [26:0] int_nxt;

  // Accelerometer fusion term: direction of the pull toward the accel angle.
`ifdef PTCH_FUSION_EN
  localparam logic signed [9:0] ACC_GAIN = 10'sd327;

  logic signed [15:0] az_diff;
  logic signed [24:0] acc_prod;
  logic signed [15:0] ptch_acc;

  always_comb begin
    az_diff  = AZ - AZ_OFFSET;
    acc_prod = 25'(az_diff) * 25'(ACC_GAIN);
    ptch_acc = 16'(acc_prod >>> 13);
    fuse     = (ptch_acc > ptch) ? 28'd1024 : -28'd1024;
  end
`else
  logic unused_az;
  assign unused_az = ^AZ;

  always_comb begin
    fuse = 28'd0;
  end
`endif

  // Calibration sum, offset compensation and saturating integrator step.
  always_comb begin
    cal_last  = (cal_cnt == CAL_LAST);
    cal_sum   = cal_acc + {{6{ptch_rt_raw[15]}}, ptch_rt_raw};

    comp_wide = {ptch_rt_raw[15], ptch_rt_raw} - {offset[15], offset};
    if (comp_wide[16] != comp_wide[15]) begin
      comp = comp_wide[16] ? 16'sh8000 : 16'sh7FFF;
    end else begin
      comp = comp_wide[15:0];
    end

    int_sum = {int_q[26], int_q} - {{12{comp[15]}}, comp} + fuse;
    if (int_sum[27] != int_sum[26]) begin
      int_nxt = int_sum[27] ? INT_MIN : INT_MAX;
    end else begin
      int_nxt = int_sum[26:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CAL;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: leave CAL on the sample that completes the average.
  always_comb begin
    state_nxt = state;
    case (state)
      CAL:     if (vld && cal_last) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = CAL;
    endcase
  end

  // Datapath registers: calibration accumulation, then per-sample outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cal_acc  <= '0;
      cal_cnt  <= '0;
      offset   <= '0;
      int_q    <= '0;
      ptch     <= '0;
      ptch_rt  <= '0;
      ptch_vld <= 1'b0;
      cal_done <= 1'b0;
    end else begin
      ptch_vld <= 1'b0;
      if (state == CAL) begin
        if (vld) begin
          cal_acc <= cal_sum;
          cal_cnt <= cal_cnt + 1'b1;
          if (cal_last) begin
            offset   <= 16'(cal_sum >>> CAL_LOG2);
            cal_done <= 1'b1;
          end
        end
      end else begin
        if (clr) begin
          int_q <= '0;
          ptch  <= '0;
        end else if (vld) begin
          ptch_rt  <= comp;
          int_q    <= int_nxt;
          ptch     <= int_nxt[26:11];
          ptch_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pitch_estimator.sv
// tb_pitch_estimator: randomized and directed stimulus for pitch_estimator,
// checked against an integer reference model through an expected-output queue.
module tb_pitch_estimator;

  localparam int          CAL_LOG2  = 4;
  localparam int          CAL_N     = 1 << CAL_LOG2;
  localparam logic [15:0] AZ_OFFSET = 16'hFE80;
`ifdef PTCH_FUSION_EN
  localparam bit FUSION_EN = 1'b1;
`else
  localparam bit FUSION_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] ptch_rt_raw = '0;
  logic [15:0] az = '0;
  logic [15:0] ptch;
  logic [15:0] ptch_rt;
  logic        ptch_vld;
  logic        cal_done;

  pitch_estimator #(.CAL_LOG2(CAL_LOG2), .AZ_OFFSET(AZ_OFFSET)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vld         (vld),
    .ptch_rt_raw (ptch_rt_raw),
    .AZ          (az),
    .clr         (clr),
    .ptch        (ptch),
    .ptch_rt     (ptch_rt),
    .ptch_vld    (ptch_vld),
    .cal_done    (cal_done)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  // Expected entries: {cycle the strobe is due, ptch, ptch_rt}.
  logic [47:0] exp_q[$];

  // Reference model state.
  int m_off, m_int, m_ptch, m_rt, cal_sum, cal_n;
  bit m_run;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic void model_reset();
    m_off = 0; m_int = 0; m_ptch = 0; m_rt = 0; cal_sum = 0; cal_n = 0; m_run = 0;
    exp_q.delete();
  endfunction

  // Reference: average during calibration, then clamp/integrate in plain integers.
  function automatic void model_step(input logic [15:0] raw, input logic [15:0] a, input logic c);
    int r, comp, fuse, d, acc;
    logic [15:0] dz;
    r = $signed(raw);
    if (!m_run) begin
      cal_sum += r;
      cal_n++;
      if (cal_n == CAL_N) begin
        m_off = cal_sum >>> CAL_LOG2;
        m_run = 1'b1;
      end
      return;
    end
    if (c) begin
      m_int = 0;
      m_ptch = 0;
      return;
    end
    comp = clamp(r - m_off, -32768, 32767);
    dz = a - AZ_OFFSET;
    d = $signed(dz);
    acc = (d * 327) >>> 13;
    fuse = FUSION_EN ? ((acc > m_ptch) ? 1024 : -1024) : 0;
    m_int = clamp(m_int - comp + fuse, -(1 << 26), (1 << 26) - 1);
    m_ptch = m_int >>> 11;
    m_rt = comp;
    exp_q.push_back({16'(cyc + 1), 16'(m_ptch), 16'(m_rt)});
  endfunction

  // Driver tasks.
  task automatic send(input logic [15:0] raw, input logic [15:0] a, input logic c);
    @(negedge clk);
    vld = 1'b1;
    ptch_rt_raw = raw;
    az = a;
    clr = c;
    model_step(raw, a, c);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vld = 1'b0;
      clr = 1'b0;
    end
  endtask

  // Monitor: strobe must appear exactly when the oldest expectation is due.
  always @(negedge clk) begin
    logic exp_strobe;
    logic [47:0] e;
    if (rst_n) begin
      exp_strobe = (exp_q.size() > 0) && (exp_q[0][47:32] == 16'(cyc));
      check("ptch_vld", {15'd0, ptch_vld}, {15'd0, exp_strobe});
      if (ptch_vld && exp_strobe) begin
        e = exp_q.pop_front();
        check("ptch", ptch, e[31:16]);
        check("ptch_rt", ptch_rt, e[15:0]);
      end
    end
  end

  // Watchdog.
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ptch", ptch, 16'h0000);
    check("rst_ptch_rt", ptch_rt, 16'h0000);
    check("rst_ptch_vld", {15'd0, ptch_vld}, 16'h0000);
    check("rst_cal_done", {15'd0, cal_done}, 16'h0000);
    rst_n = 1'b1;

    // Calibration with a constant raw rate.
    repeat (CAL_N - 1) send(16'h0050, AZ_OFFSET, 1'b0);
    idle(1);
    check("cal_done_before_last", {15'd0, cal_done}, 16'h0000);
    check("cal_ptch", ptch, 16'h0000);
    check("cal_ptch_rt", ptch_rt, 16'h0000);
    send(16'h0050, AZ_OFFSET, 1'b1);
    idle(1);
    check("cal_done_after_last", {15'd0, cal_done}, 16'h0001);

    // First RUN sample equals the offset.
    send(16'h0050, AZ_OFFSET, 1'b0);
    idle(1);
    check("first_run_ptch_rt", ptch_rt, 16'h0000);

    // Integration from zero.
    send(16'h0000, AZ_OFFSET, 1'b1);
    repeat (4) send(16'h0850, AZ_OFFSET, 1'b0);
    idle(1);
    check("integ_ptch_rt", ptch_rt, 16'h0800);
`ifndef PTCH_FUSION_EN
    check("integ_ptch_after_4", ptch, 16'hFFFC);
`endif

    // clr with vld: clr wins, no strobe, ptch_rt kept.
    send(16'h0850, AZ_OFFSET, 1'b1);
    idle(1);
    check("clr_ptch", ptch, 16'h0000);
    check("clr_ptch_rt", ptch_rt, 16'(m_rt));
    send(16'h0850, AZ_OFFSET, 1'b0);
    idle(1);
`ifndef PTCH_FUSION_EN
    check("clr_resume_ptch", ptch, 16'hFFFF);
`endif

`ifdef PTCH_FUSION_EN
    // Fusion pull with zero gyro rate.
    send(16'h0000, AZ_OFFSET, 1'b1);
    repeat (2) send(16'h0050, AZ_OFFSET + 16'h1000, 1'b0);
    idle(1);
    check("fusion_ptch", ptch, 16'h0001);
    check("fusion_ptch_rt", ptch_rt, 16'h0000);
`endif

    // Randomized run with occasional clr and gaps.
    for (int i = 0; i < 400; i++) begin
      send(16'($urandom), 16'($urandom), ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(1);

    // Rate saturation and integrator clamping at both limits.
    send(16'h8000, AZ_OFFSET, 1'b0);
    idle(1);
    check("sat_ptch_rt", ptch_rt, 16'h8000);
    send(16'h0000, AZ_OFFSET, 1'b1);
    repeat (2200) send(16'(m_off - 32767), AZ_OFFSET, 1'b0);
    idle(1);
    check("sat_pos_ptch", ptch, 16'h7FFF);
    repeat (4400) send(16'h7FFF, AZ_OFFSET, 1'b0);
    idle(1);
    check("sat_neg_ptch", ptch, 16'h8000);

    // Mid-operation asynchronous reset.
    idle(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ptch", ptch, 16'h0000);
    check("midrst_ptch_rt", ptch_rt, 16'h0000);
    check("midrst_ptch_vld", {15'd0, ptch_vld}, 16'h0000);
    check("midrst_cal_done", {15'd0, cal_done}, 16'h0000);
    model_reset();
    idle(2);
    rst_n = 1'b1;

    // Fresh calibration with random raw values, then random run.
    repeat (CAL_N - 1) send(16'($urandom), 16'($urandom), 1'b0);
    idle(1);
    check("recal_done_before_last", {15'd0, cal_done}, 16'h0000);
    send(16'($urandom), 16'($urandom), 1'b0);
    idle(1);
    check("recal_done_after_last", {15'd0, cal_done}, 16'h0001);
    for (int i = 0; i < 60; i++) begin
      send(16'($urandom_range(0, 65535)), 16'($urandom), ($urandom_range(0, 15) == 0));
    end
    idle(3);
    check("queue_drained", 16'(exp_q.size()), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
